// File: rtl/fp_add_pipe.sv
// fp_add_pipe: pipelined FP add/sub, 3-cycle latency, 1 result/cycle; whole pipe stalls together (in_ready = !out_valid | out_ready).
// FP_ADD_RNE_EN selects round-to-nearest-even; otherwise the result is truncated.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     op_sub,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int AW  = MAN_W + 4;
  localparam int SW  = MAN_W + 5;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(AW);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic             sign_a, sign_b, zero_a, zero_b, nan_a, nan_b, inf_a, inf_b, swap;
  logic [EXP_W-1:0] exp_a, exp_b, big_exp, small_exp, shift;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic [MAN_W:0]   man_a, man_b, big_man, small_man;
  logic [AW-1:0]    small_ext, aligned;
  logic             spec;
  logic [W-1:0]     spec_val;

  assign {sign_a, exp_a, frac_a} = a;
  assign sign_b    = b[W-1] ^ op_sub;
  assign exp_b     = b[W-2:MAN_W];
  assign frac_b    = b[MAN_W-1:0];
  assign zero_a    = (exp_a == '0);
  assign zero_b    = (exp_b == '0);
  assign nan_a     = (exp_a == EXP_ONES) && (frac_a != '0);
  assign nan_b     = (exp_b == EXP_ONES) && (frac_b != '0);
  assign inf_a     = (exp_a == EXP_ONES) && (frac_a == '0);
  assign inf_b     = (exp_b == EXP_ONES) && (frac_b == '0);
  assign man_a     = zero_a ? '0 : {1'b1, frac_a};
  assign man_b     = zero_b ? '0 : {1'b1, frac_b};
  assign swap      = {exp_b, man_b} > {exp_a, man_a};
  assign big_exp   = swap ? exp_b : exp_a;
  assign small_exp = swap ? exp_a : exp_b;
  assign big_man   = swap ? man_b : man_a;
  assign small_man = swap ? man_a : man_b;
  assign shift     = big_exp - small_exp;
  assign small_ext = {small_man, 3'b000};

  // Bits shifted out past the guard/round positions fold into the sticky bit.
  always_comb begin
    aligned = '0;
    if (int'(shift) >= AW - 1)
      aligned[0] = |small_man;
    else
      aligned = (small_ext >> shift) | AW'(|(small_ext & ~({AW{1'b1}} << shift)));
  end

  always_comb begin
    spec     = 1'b1;
    spec_val = '0;
    if (nan_a || nan_b)       spec_val = QNAN;
    else if (inf_a && inf_b)  spec_val = (sign_a == sign_b) ? {sign_a, EXP_ONES, {MAN_W{1'b0}}} : QNAN;
    else if (inf_a)           spec_val = {sign_a, EXP_ONES, {MAN_W{1'b0}}};
    else if (inf_b)           spec_val = {sign_b, EXP_ONES, {MAN_W{1'b0}}};
    else if (zero_a && zero_b) spec_val = {sign_a & sign_b, {(W-1){1'b0}}};
    else                      spec     = 1'b0;
  end

  logic             s1_vld, s1_spec, s1_sign, s1_sub;
  logic [W-1:0]     s1_spec_val;
  logic [EXP_W-1:0] s1_exp;
  logic [AW-1:0]    s1_big, s1_small;
  logic             s2_vld, s2_spec, s2_sign;
  logic [W-1:0]     s2_spec_val;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0]    s2_sum, sum;

  assign sum = s1_sub ? {1'b0, s1_big} - {1'b0, s1_small}
                      : {1'b0, s1_big} + {1'b0, s1_small};

  logic [LZW-1:0]   lzc;
  logic             carry;
  logic [EW-1:0]    exp_n, exp_r;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     res_d;
  logic             ovf_d, unf_d;

  always_comb begin
    lzc = '0;
    for (int i = 0; i < AW; i++)
      if (s2_sum[i]) lzc = LZW'(AW - 1 - i);
  end

  assign carry = s2_sum[SW-1];
  assign exp_n = carry ? {2'b00, s2_exp} + EW'(1) : {2'b00, s2_exp} - EW'(lzc);

`ifdef FP_ADD_RNE_EN
  logic [MAN_W+2:0] fgrs;
  logic             rc;
  assign fgrs       = carry ? {s2_sum[SW-2:2], |s2_sum[1:0]} : (MAN_W+3)'(s2_sum[AW-1:0] << lzc);
  assign {rc, frac} = {1'b0, fgrs[MAN_W+2:3]} + (MAN_W+1)'(fgrs[2] & (fgrs[1] | fgrs[0] | fgrs[3]));
  assign exp_r      = exp_n + EW'(rc);
`else
  assign frac  = carry ? s2_sum[SW-2:4] : MAN_W'((s2_sum[AW-1:0] << lzc) >> 3);
  assign exp_r = exp_n;
`endif

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s2_spec) begin
      res_d = s2_spec_val;
    end else if (s2_sum == '0) begin
      res_d = '0;
    end else if (exp_n[EW-1] || exp_n == '0) begin
      res_d = {s2_sign, {(W-1){1'b0}}};
      unf_d = 1'b1;
    end else if (exp_r >= {2'b00, EXP_ONES}) begin
      res_d = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else begin
      res_d = {s2_sign, exp_r[EXP_W-1:0], frac};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0; s1_spec <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0;
      s1_spec_val <= '0; s1_exp <= '0; s1_big <= '0; s1_small <= '0;
      s2_vld <= 1'b0; s2_spec <= 1'b0; s2_sign <= 1'b0;
      s2_spec_val <= '0; s2_exp <= '0; s2_sum <= '0;
      out_valid <= 1'b0; result <= '0; overflow <= 1'b0; underflow <= 1'b0;
    end else if (en) begin
      s1_vld      <= in_valid;
      s1_spec     <= spec;
      s1_spec_val <= spec_val;
      s1_sign     <= swap ? sign_b : sign_a;
      s1_sub      <= sign_a ^ sign_b;
      s1_exp      <= big_exp;
      s1_big      <= {big_man, 3'b000};
      s1_small    <= aligned;
      s2_vld      <= s1_vld;
      s2_spec     <= s1_spec;
      s2_spec_val <= s1_spec_val;
      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum;
      out_valid   <= s2_vld;
      result      <= res_d;
      overflow    <= s2_vld & ovf_d;
      underflow   <= s2_vld & unf_d;
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe (EXP_W=8, MAN_W=23): special values, rounding, stall and reset.
module tb_fp_add_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, op_sub, out_valid, out_ready, overflow, underflow;
  logic [31:0] a, b, result;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow)
  );

  // Operands 1.0 .. 8.0; doubling each only bumps the exponent field.
  logic [31:0] opv [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

`ifdef FP_ADD_RNE_EN
  localparam logic [31:0] RND_TIE_ODD = 32'h3F800002;
  localparam logic [31:0] RND_CARRY   = 32'h40000000;
`else
  localparam logic [31:0] RND_TIE_ODD = 32'h3F800001;
  localparam logic [31:0] RND_CARRY   = 32'h3FFFFFFF;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present one op at a negedge, then check out_valid timing and {result, overflow, underflow}.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic s, input logic [31:0] er, input logic eo, input logic eu);
    a = ta; b = tb_; op_sub = s; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); chk({tag, " early"}, 64'(out_valid), 64'd0);
    @(negedge clk); chk({tag, " valid"}, 64'(out_valid), 64'd1);
    chk(tag, 64'({result, overflow, underflow}), 64'({er, eo, eu}));
  endtask

  logic saw_stall, saw_valid;
  int   sent, got;

  initial begin
    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", 64'({result, overflow, underflow}), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle in_ready", 64'(in_ready), 64'd1);

    run_op("1+1",          32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
    run_op("3+-1.5",       32'h40400000, 32'hBFC00000, 1'b0, 32'h3FC00000, 1'b0, 1'b0);
    run_op("1-1",          32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    run_op("max+max",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
    run_op("inf-inf",      32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0);
    run_op("round tie",    32'h3F800001, 32'h33800000, 1'b0, RND_TIE_ODD,  1'b0, 1'b0);
    run_op("round carry",  32'h3FFFFFFF, 32'h33800000, 1'b0, RND_CARRY,    1'b0, 1'b0);
    run_op("1-2",          32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0);
    run_op("underflow",    32'h01000000, 32'h00C00000, 1'b1, 32'h00000000, 1'b0, 1'b1);
    run_op("-0+-0",        32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0);
    run_op("nan in",       32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0);
    run_op("-inf+1",       32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0);
    run_op("denorm flush", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);

    // Drain the last result, then stream 8 ops with out_ready low in cycles 2-6.
    @(negedge clk);
    sent = 0; got = 0; saw_stall = 1'b0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 2 && c <= 6);
      in_valid  = (sent < 8);
      a = opv[sent % 8]; b = opv[sent % 8]; op_sub = 1'b0;
      #1;
      if (!in_ready) saw_stall = 1'b1;
      if (c == 6) chk("stall hold", 64'({out_valid, result}), 64'({1'b1, opv[0] + 32'h00800000}));
      if (out_valid && out_ready) begin
        if (got < 8) chk("stream", 64'(result), 64'(opv[got] + 32'h00800000));
        else         chk("extra result", 64'd1, 64'd0);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("all sent", 64'(sent), 64'd8);
    chk("all received", 64'(got), 64'd8);
    chk("in_ready stalled", 64'(saw_stall), 64'd1);

    // Reset with two ops in flight: outputs clear at once, nothing stale afterwards.
    a = 32'h3F800000; b = 32'h3F800000; op_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async reset valid", 64'(out_valid), 64'd0);
    chk("async reset result", 64'({result, overflow, underflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    chk("no stale result", 64'(saw_valid), 64'd0);
    chk("post-reset in_ready", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
